// File: rtl/io_pkg.sv
// Shared constants for the I/O command responder: command codes, INSW states
// and the seven-segment glyph table ({g,f,e,d,c,b,a}, active-low).
package io_pkg;

  localparam logic [1:0] HI_NONE = 2'd0;
  localparam logic [1:0] HI_LED  = 2'd1;
  localparam logic [1:0] HI_SS   = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DONE,
    RELEASE
  } insw_state_t;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/io_handler_if.sv
// Control-core side of the I/O responder: command code, INSW request,
// operand, captured switch value and the datapath stall.
interface io_handler_if;

  logic [1:0]  controlHI;
  logic        controlMDH;
  logic [31:0] data_in;
  logic [31:0] sw_data;
  logic        stall;

  modport master (
    output controlHI, controlMDH, data_in,
    input  sw_data, stall
  );

  modport slave (
    input  controlHI, controlMDH, data_in,
    output sw_data, stall
  );

endinterface

// File: rtl/io_debouncer.sv
// ENTER button conditioning: two-flop synchronizer, stability counter and a
// one-cycle press pulse that coincides with the edge that accepts a press.
module io_debouncer #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic stable,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Any return to the stable level restarts the count, so short bounces never flip it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = stable & ~sync2 & (cnt == LAST);

endmodule

// File: rtl/io_handler.sv
// Peripheral responder executing OUTLED, OUTSS and INSW against the board:
// LED register, multiplexed 8-digit display and the switch-read handshake.
module io_handler #(
  parameter int SW_W      = 16,
  parameter int LED_W     = 16,
  parameter int SCAN_DIV  = 16,
  parameter int DB_CYCLES = 50000
) (
  input  logic             clock,
  input  logic             reset,
  io_handler_if.slave      bus,
  input  logic [SW_W-1:0]  switches,
  input  logic             enter_n,
  output logic [LED_W-1:0] leds,
  output logic [7:0]       anode_n,
  output logic [6:0]       segment_n
);

  import io_pkg::*;

  logic [31:0]         disp;
  logic [SCAN_DIV-1:0] scan_cnt;
  logic [2:0]          digit;
  logic                stable;
  logic                press;
  logic                capture;
  insw_state_t         state;
  insw_state_t         next_state;

  io_debouncer #(.DB_CYCLES(DB_CYCLES)) u_debouncer (
    .clock  (clock),
    .reset  (reset),
    .btn_n  (enter_n),
    .stable (stable),
    .press  (press)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      leds <= '0;
      disp <= '0;
    end else begin
      case (bus.controlHI)
        HI_LED:  leds <= bus.data_in[LED_W-1:0];
        HI_SS:   disp <= bus.data_in;
        default: ;
      endcase
    end
  end

  assign digit = scan_cnt[SCAN_DIV-1 -: 3];

  // Digit drivers are registered so the board sees glitch-free anode/segment lines.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      anode_n   <= 8'hFF;
      segment_n <= 7'h7F;
    end else begin
      scan_cnt  <= scan_cnt + SCAN_DIV'(1);
      anode_n   <= ~(8'b1 << digit);
      segment_n <= SEG_TABLE[disp[{digit, 2'b00} +: 4]];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // RELEASE waits for the button to come back up so a held press never serves two reads.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      IDLE:    if (bus.controlMDH) next_state = ARMED;
      ARMED: begin
        if (!bus.controlMDH) begin
          next_state = IDLE;
        end else if (press) begin
          next_state = DONE;
          capture    = 1'b1;
        end
      end
      DONE:    next_state = RELEASE;
      RELEASE: if (stable) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.sw_data <= '0;
    end else if (capture) begin
      bus.sw_data <= 32'(switches);
    end
  end

  assign bus.stall = bus.controlMDH & (state != DONE);

endmodule

// File: tb/tb_io_handler.sv
// Scenario bench for io_handler: LED/display commands, display scan rotation
// and the INSW press handshake, checked against an arithmetic reference model.
module tb_io_handler;

  localparam int DB = 4;
  localparam int SD = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] switches;
  logic        enter_n;
  logic [15:0] leds;
  logic [7:0]  anode_n;
  logic [6:0]  segment_n;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [15:0] leds_m;
  logic [31:0] disp_m;
  logic [6:0]  glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  io_handler_if bus();

  io_handler #(
    .SW_W(16), .LED_W(16), .SCAN_DIV(SD), .DB_CYCLES(DB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .switches  (switches),
    .enter_n   (enter_n),
    .leds      (leds),
    .anode_n   (anode_n),
    .segment_n (segment_n)
  );

  always #5 clock = ~clock;

  // Clock edges seen since reset was last released.
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    bus.controlHI  = 2'd0;
    bus.controlMDH = 1'b1;
    bus.data_in    = '0;
    switches       = '0;
    enter_n        = 1'b1;
    #1 reset = 1'b0;
    #20;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_stall_follows_mdh: got %b expected 1", bus.stall); end
    checks++; if (leds !== 16'h0) begin errors++; $display("[TB] FAIL reset_leds: got %h expected 0000", leds); end
    checks++; if (anode_n !== 8'hFF) begin errors++; $display("[TB] FAIL reset_anode: got %h expected ff", anode_n); end
    checks++; if (segment_n !== 7'h7F) begin errors++; $display("[TB] FAIL reset_segment: got %b expected 1111111", segment_n); end
    checks++; if (bus.sw_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_sw_data: got %h expected 0", bus.sw_data); end
    bus.controlMDH = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_low: got %b expected 0", bus.stall); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (anode_n !== 8'hFF) begin errors++; $display("[TB] FAIL anode_before_scan: got %h expected ff", anode_n); end
    @(negedge clock);
    checks++; if (anode_n !== 8'hFE) begin errors++; $display("[TB] FAIL first_scan_anode: got %h expected fe", anode_n); end
    checks++; if (segment_n !== 7'b1000000) begin errors++; $display("[TB] FAIL first_scan_segment: got %b expected 1000000", segment_n); end
    leds_m = '0;
    disp_m = '0;
  endtask

  task automatic test_leds;
    logic [1:0]  code;
    logic [31:0] data;
    bus.controlHI = 2'd1;
    bus.data_in   = 32'h0001A5A5;
    tick();
    leds_m = 16'hA5A5;
    checks++; if (leds !== leds_m) begin errors++; $display("[TB] FAIL outled_load: got %h expected %h", leds, leds_m); end
    bus.controlHI = 2'd3;
    bus.data_in   = $urandom;
    tick();
    checks++; if (leds !== leds_m) begin errors++; $display("[TB] FAIL reserved_code_hold: got %h expected %h", leds, leds_m); end
    for (int i = 0; i < 12; i++) begin
      code = 2'($urandom_range(0, 3));
      data = $urandom;
      bus.controlHI = code;
      bus.data_in   = data;
      tick();
      if (code == 2'd1) leds_m = data[15:0];
      if (code == 2'd2) disp_m = data;
      checks++; if (leds !== leds_m) begin errors++; $display("[TB] FAIL random_leds[%0d] code %0d: got %h expected %h", i, code, leds, leds_m); end
    end
    bus.controlHI = 2'd0;
  endtask

  task automatic test_scan(input logic [31:0] value);
    int d;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    bus.controlHI = 2'd2;
    bus.data_in   = value;
    tick();
    bus.controlHI = 2'd0;
    bus.data_in   = $urandom;
    disp_m = value;
    tick();
    for (int i = 0; i < 40; i++) begin
      tick();
      d = ((cyc - 1) / 4) % 8;
      exp_an  = ~(8'b1 << d);
      exp_seg = glyph[(disp_m >> (4 * d)) & 32'hF];
      checks++; if (anode_n !== exp_an) begin errors++; $display("[TB] FAIL scan_anode cyc %0d: got %h expected %h", cyc, anode_n, exp_an); end
      checks++; if (segment_n !== exp_seg) begin errors++; $display("[TB] FAIL scan_segment digit %0d: got %b expected %b", d, segment_n, exp_seg); end
    end
  endtask

  task automatic test_insw;
    int n;
    switches = 16'h1234;
    bus.controlMDH = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL insw_request_stall: got %b expected 1", bus.stall); end
    @(negedge clock);
    enter_n = 1'b0;
    tick(2);
    enter_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL glitch_stall[%0d]: got %b expected 1", i, bus.stall); end
    end
    enter_n = 1'b0;
    n = 0;
    while (n < DB + 10) begin
      tick();
      n++;
      if (bus.stall == 1'b0) break;
    end
    checks++; if (n != DB + 2) begin errors++; $display("[TB] FAIL press_latency: got %0d cycles expected %0d", n, DB + 2); end
    checks++; if (bus.sw_data !== 32'h00001234) begin errors++; $display("[TB] FAIL insw_capture: got %h expected 00001234", bus.sw_data); end
    tick();
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL stall_one_cycle: got %b expected 1", bus.stall); end
    checks++; if (dut.state !== io_pkg::RELEASE) begin errors++; $display("[TB] FAIL state_release: got %0d expected %0d", dut.state, io_pkg::RELEASE); end
    bus.controlMDH = 1'b0;
    enter_n = 1'b1;
    tick(DB + 4);
    checks++; if (dut.state !== io_pkg::IDLE) begin errors++; $display("[TB] FAIL idle_after_release: got %0d expected %0d", dut.state, io_pkg::IDLE); end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [15:0] sw1;
    logic [15:0] sw2;
    sw1 = 16'($urandom);
    sw2 = 16'($urandom);
    if (sw2 == sw1) sw2 = ~sw1;
    switches = sw1;
    bus.controlMDH = 1'b1;
    enter_n = 1'b0;
    n = 0;
    while (n < DB + 10) begin
      tick();
      n++;
      if (bus.stall == 1'b0) break;
    end
    checks++; if (n != DB + 2) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d expected %0d", n, DB + 2); end
    checks++; if (bus.sw_data !== {16'h0, sw1}) begin errors++; $display("[TB] FAIL b2b_first_capture: got %h expected %h", bus.sw_data, {16'h0, sw1}); end
    switches = sw2;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL held_button_stall[%0d]: got %b expected 1", i, bus.stall); end
    end
    enter_n = 1'b1;
    for (int i = 0; i < DB + 6; i++) begin
      tick();
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL release_stall[%0d]: got %b expected 1", i, bus.stall); end
    end
    checks++; if (bus.sw_data !== {16'h0, sw1}) begin errors++; $display("[TB] FAIL b2b_hold_value: got %h expected %h", bus.sw_data, {16'h0, sw1}); end
    enter_n = 1'b0;
    n = 0;
    while (n < DB + 10) begin
      tick();
      n++;
      if (bus.stall == 1'b0) break;
    end
    checks++; if (n != DB + 2) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", n, DB + 2); end
    checks++; if (bus.sw_data !== {16'h0, sw2}) begin errors++; $display("[TB] FAIL b2b_second_capture: got %h expected %h", bus.sw_data, {16'h0, sw2}); end
    bus.controlMDH = 1'b0;
    enter_n = 1'b1;
    tick(DB + 4);
  endtask

  task automatic test_reset_armed;
    bus.controlMDH = 1'b1;
    tick();
    checks++; if (dut.state !== io_pkg::ARMED) begin errors++; $display("[TB] FAIL armed_before_reset: got %0d expected %0d", dut.state, io_pkg::ARMED); end
    #2 reset = 1'b0;
    #1;
    checks++; if (dut.state !== io_pkg::IDLE) begin errors++; $display("[TB] FAIL reset_armed_state: got %0d expected %0d", dut.state, io_pkg::IDLE); end
    checks++; if (bus.sw_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_armed_sw_data: got %h expected 0", bus.sw_data); end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_armed_stall: got %b expected 1", bus.stall); end
    @(negedge clock);
    reset = 1'b1;
    bus.controlMDH = 1'b0;
    tick();
    switches = 16'($urandom) | 16'h0001;
    bus.controlMDH = 1'b1;
    tick();
    checks++; if (dut.state !== io_pkg::ARMED) begin errors++; $display("[TB] FAIL flush_armed: got %0d expected %0d", dut.state, io_pkg::ARMED); end
    bus.controlMDH = 1'b0;
    tick();
    checks++; if (dut.state !== io_pkg::IDLE) begin errors++; $display("[TB] FAIL flush_idle: got %0d expected %0d", dut.state, io_pkg::IDLE); end
    enter_n = 1'b0;
    for (int i = 0; i < DB + 6; i++) begin
      tick();
      checks++; if (bus.sw_data !== 32'h0) begin errors++; $display("[TB] FAIL flush_no_capture[%0d]: got %h expected 0", i, bus.sw_data); end
    end
    enter_n = 1'b1;
    tick(DB + 4);
    checks++; if (dut.state !== io_pkg::IDLE) begin errors++; $display("[TB] FAIL flush_final_state: got %0d expected %0d", dut.state, io_pkg::IDLE); end
  endtask

  initial begin
    test_reset();
    test_leds();
    test_scan(32'h000000F8);
    test_scan($urandom);
    test_insw();
    test_back_to_back();
    test_reset_armed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
